// File: rtl/regfile_wb_arb.sv
// Write-back arbiter and busy scoreboard for the 16x16 register file.
// Define WB_RR_EN for round-robin arbitration; otherwise fixed priority B over A.
module regfile_wb_arb #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_sel,
  input  logic [DW-1:0]    a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_sel,
  input  logic [DW-1:0]    b_data,
  output logic             b_ready,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_sel,
  output logic             rsv_ok,
  input  logic             flush,
  output logic [2**AW-1:0] busy,
  output logic             wen,
  output logic [AW-1:0]    selRd,
  output logic [DW-1:0]    rd
);

  localparam int unsigned NR = 2 ** AW;

  logic          aGrant;
  logic          bGrant;
  logic          wenQ;
  logic [AW-1:0] selRdQ;
  logic [DW-1:0] rdQ;
  logic [NR-1:0] busyQ;
  logic [NR-1:0] busyD;

`ifdef WB_RR_EN
  // 0 = A granted last, 1 = B; reset to B so A wins the first contest
  logic lastQ;

  always_comb begin
    aGrant = 1'b0;
    bGrant = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        aGrant = lastQ;
        bGrant = ~lastQ;
      end else begin
        aGrant = a_valid;
        bGrant = b_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastQ <= 1'b1;
    end else if (aGrant) begin
      lastQ <= 1'b0;
    end else if (bGrant) begin
      lastQ <= 1'b1;
    end
  end
`else
  always_comb begin
    aGrant = 1'b0;
    bGrant = 1'b0;
    if (!rst) begin
      bGrant = b_valid;
      aGrant = a_valid & ~b_valid;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wenQ   <= 1'b0;
      selRdQ <= '0;
      rdQ    <= '0;
    end else begin
      wenQ <= aGrant | bGrant;
      if (aGrant) begin
        selRdQ <= a_sel;
        rdQ    <= a_data;
      end else if (bGrant) begin
        selRdQ <= b_sel;
        rdQ    <= b_data;
      end
    end
  end

  // A register being written this cycle may be reserved again immediately
  assign rsv_ok = rsv_en & (~busyQ[rsv_sel] | (wenQ & (selRdQ == rsv_sel)));

  always_comb begin
    busyD = busyQ;
    if (wenQ) begin
      busyD[selRdQ] = 1'b0;
    end
    if (rsv_ok) begin
      busyD[rsv_sel] = 1'b1;
    end
    if (flush) begin
      busyD = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyD;
    end
  end

  assign a_ready = aGrant;
  assign b_ready = bGrant;
  assign busy    = busyQ;
  assign wen     = wenQ;
  assign selRd   = selRdQ;
  assign rd      = rdQ;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed self-checking bench for regfile_wb_arb; expectations follow WB_RR_EN.
module tb_regfile_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, rsv_en, flush;
  logic [3:0]  a_sel, b_sel, rsv_sel;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, rsv_ok, wen;
  logic [15:0] busy, rd;
  logic [3:0]  selRd;

  int checks = 0;
  int errors = 0;

  regfile_wb_arb #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_ok(rsv_ok),
    .flush(flush), .busy(busy), .wen(wen), .selRd(selRd), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkWr(input string tag, input logic [3:0] s, input logic [15:0] d);
    chk({tag, " wen"}, {31'd0, wen}, 32'd1);
    chk({tag, " selRd"}, {28'd0, selRd}, {28'd0, s});
    chk({tag, " rd"}, {16'd0, rd}, {16'd0, d});
  endtask

  logic rr;
  logic expA;

  initial begin
`ifdef WB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst = 1'b1;
    a_valid = 1'b1; a_sel = '0; a_data = '0;
    b_valid = 1'b0; b_sel = '0; b_data = '0;
    rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0;
    #1;
    chk("reset wen", {31'd0, wen}, 32'd0);
    chk("reset busy", {16'd0, busy}, 32'd0);
    chk("reset selRd", {28'd0, selRd}, 32'd0);
    chk("reset rd", {16'd0, rd}, 32'd0);
    chk("reset a_ready low", {31'd0, a_ready}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; a_valid = 1'b0;

    // Single A write
    @(negedge clk);
    a_valid = 1'b1; a_sel = 4'd3; a_data = 16'h1234;
    #1;
    chk("A solo a_ready", {31'd0, a_ready}, 32'd1);
    chk("A solo b_ready", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    chkWr("A solo write", 4'd3, 16'h1234);
    @(negedge clk);
    chk("A solo wen drop", {31'd0, wen}, 32'd0);
    chk("A solo selRd hold", {28'd0, selRd}, 32'd3);

    // Single B write leaves last=B
    b_valid = 1'b1; b_sel = 4'd9; b_data = 16'h0009;
    #1;
    chk("B solo b_ready", {31'd0, b_ready}, 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    chkWr("B solo write", 4'd9, 16'h0009);

    // Contested: alternate under round-robin, B always under fixed priority
    a_valid = 1'b1; a_sel = 4'd1; a_data = 16'hAAAA;
    b_valid = 1'b1; b_sel = 4'd2; b_data = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      expA = rr && (i % 2 == 0);
      #1;
      chk($sformatf("contest %0d a_ready", i), {31'd0, a_ready}, {31'd0, expA});
      chk($sformatf("contest %0d b_ready", i), {31'd0, b_ready}, {31'd0, ~expA});
      @(negedge clk);
      if (expA) chkWr($sformatf("contest %0d", i), 4'd1, 16'hAAAA);
      else chkWr($sformatf("contest %0d", i), 4'd2, 16'hBBBB);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("contest wen drop", {31'd0, wen}, 32'd0);

    // Reserve R5, re-reserve rejected, B write clears it
    rsv_en = 1'b1; rsv_sel = 4'd5;
    #1;
    chk("rsv5 ok", {31'd0, rsv_ok}, 32'd1);
    @(negedge clk);
    chk("rsv5 busy", {16'd0, busy}, 32'h0020);
    #1;
    chk("rsv5 again rejected", {31'd0, rsv_ok}, 32'd0);
    @(negedge clk);
    rsv_en = 1'b0;
    b_valid = 1'b1; b_sel = 4'd5; b_data = 16'h5555;
    @(negedge clk);
    b_valid = 1'b0;
    chkWr("B write R5", 4'd5, 16'h5555);
    chk("R5 busy during wen", {16'd0, busy}, 32'h0020);
    @(negedge clk);
    chk("R5 busy cleared", {16'd0, busy}, 32'h0000);

    // Reserve R7 and write it; re-reserve on the wen cycle keeps bit set
    rsv_en = 1'b1; rsv_sel = 4'd7;
    a_valid = 1'b1; a_sel = 4'd7; a_data = 16'h7777;
    #1;
    chk("rsv7 ok", {31'd0, rsv_ok}, 32'd1);
    chk("A7 a_ready", {31'd0, a_ready}, 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("R7 busy", {16'd0, busy}, 32'h0080);
    chkWr("A write R7", 4'd7, 16'h7777);
    #1;
    chk("rsv7 during wen ok", {31'd0, rsv_ok}, 32'd1);
    @(negedge clk);
    rsv_en = 1'b0;
    chk("R7 stays busy", {16'd0, busy}, 32'h0080);

    // Build busy=0x00F0 with a write to R4 in the write stage, then flush
    for (int r = 4; r < 7; r++) begin
      rsv_en = 1'b1; rsv_sel = 4'(r);
      #1;
      chk($sformatf("rsv%0d ok", r), {31'd0, rsv_ok}, 32'd1);
      @(negedge clk);
    end
    rsv_en = 1'b0;
    a_valid = 1'b1; a_sel = 4'd4; a_data = 16'h4444;
    @(negedge clk);
    a_valid = 1'b0;
    chk("pre-flush busy", {16'd0, busy}, 32'h00F0);
    chkWr("R4 in write stage", 4'd4, 16'h4444);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {16'd0, busy}, 32'h0000);
    chk("after flush wen", {31'd0, wen}, 32'd0);
    chk("after flush selRd", {28'd0, selRd}, 32'd4);

    // Asynchronous reset with a write in flight
    a_valid = 1'b1; a_sel = 4'hA; a_data = 16'hABCD;
    rsv_en = 1'b1; rsv_sel = 4'hC;
    @(negedge clk);
    rsv_en = 1'b0;
    chkWr("pre-reset write", 4'hA, 16'hABCD);
    chk("pre-reset busy", {16'd0, busy}, 32'h1000);
    #2 rst = 1'b1;
    #1;
    chk("async rst wen", {31'd0, wen}, 32'd0);
    chk("async rst busy", {16'd0, busy}, 32'd0);
    chk("async rst selRd", {28'd0, selRd}, 32'd0);
    chk("async rst rd", {16'd0, rd}, 32'd0);
    chk("async rst a_ready", {31'd0, a_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First contest after reset: A under round-robin, B under fixed priority
    b_valid = 1'b1; b_sel = 4'd2; b_data = 16'hBBBB;
    #1;
    chk("post-reset contest a_ready", {31'd0, a_ready}, {31'd0, rr});
    chk("post-reset contest b_ready", {31'd0, b_ready}, {31'd0, ~rr});
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-back arbiter and scoreboard for the 16x16-bit register file. Two write-back sources share the single register-file write port: A (ALU) and B (load unit). The block grants one source per cycle and drives `wen`/`selRd`/`rd` from a register stage. It also keeps a 16-bit busy mask of registers with pending writes, which the issue logic uses for RAW/WAW hazard stalls.

## Interface
Parameters:
- `DW`, 16, write data width; must match the register-file data width.
- `AW`, 4, register select width; the busy mask is 2**AW bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `a_valid`  in  1  source A has a write pending.
- `a_sel`  in  AW  source A destination register.
- `a_data`  in  DW  source A write data.
- `a_ready`  out  1  source A granted this cycle (combinational).
- `b_valid`, `b_sel`, `b_data`, `b_ready`  same as the A ports, for source B.
- `rsv_en`  in  1  issue logic requests a reservation of `rsv_sel`.
- `rsv_sel`  in  AW  register to reserve.
- `rsv_ok`  out  1  reservation accepted this cycle (combinational).
- `flush`  in  1  synchronous clear of the busy mask.
- `busy`  out  2**AW  registers with an outstanding write.
- `wen`  out  1  register-file write enable (registered).
- `selRd`  out  AW  register-file write select (registered).
- `rd`  out  DW  register-file write data (registered).

## Operation
- A transfer completes on any edge where `x_valid & x_ready` is high.
- Sources hold `x_valid`, `x_sel` and `x_data` stable until they are granted.
- `x_ready` is never high unless `x_valid` is high.
- At most one grant per cycle. `a_ready & b_ready` is never 1.
- Arbitration is round-robin over one pointer, `last`, with 0 meaning A:
  - One requester valid: it is granted.
  - Both valid: grant the source that is not `last`.
  - `last` updates only on a grant.
  - Reset value of `last` selects B, so A wins the first contested cycle.
- Write stage, on the edge after a grant:
  - `wen` = 1.
  - `selRd` = granted sel.
  - `rd` = granted data.
- With no grant, `wen` = 0 and `selRd`/`rd` hold their last values.
- Scoreboard set/clear:
  - `rsv_ok` = `rsv_en & (~busy[rsv_sel] | (wen & selRd==rsv_sel))`.
  - On `rsv_ok`, `busy[rsv_sel]` is set.
  - On `wen`, `busy[selRd]` is cleared.
  - Set and clear of the same index in the same cycle: the bit stays 1 (the new reservation wins).
- `flush`:
  - Clears every busy bit, and has priority over a same-cycle set or clear.
  - A write already in the write stage still commits.
  - Arbitration is unaffected.
- A write to a register that is not busy is legal. It commits, and the clear is a no-op.

## Timing
- Reset values: `wen`=0, `selRd`=0, `rd`=0, `busy`=0, `last`=B.
- `a_ready`/`b_ready` are low while `rst` is high.
- Grant-to-write latency is 1 cycle. Back-to-back grants give `wen` high on consecutive cycles, with full throughput.
- `a_ready`, `b_ready` and `rsv_ok` are combinational from the inputs and registered state. There is no combinational path from `x_valid` to `wen`.
- The `busy` bit is cleared on the same edge the register file captures the data. The issue logic sees it low one cycle after `wen`.
- Reset asserted mid-operation:
  - A pending write-stage write is discarded (`wen` drops immediately).
  - The busy mask is cleared.
  - Sources must re-present their requests after reset.

## Configuration
- `WB_RR_EN` defined: round-robin arbitration as above.
- `WB_RR_EN` undefined:
  - Fixed priority, B (load) over A.
  - `last` is not implemented.
  - A can starve while B stays valid.

## Test plan
- Reset, then `a_valid`=1 with `a_sel`=3, `a_data`=0x1234 for one cycle -> `a_ready`=1; the next cycle has `wen`=1, `selRd`=3, `rd`=0x1234; one cycle later `wen`=0.
- A and B both valid for 4 cycles (A: sel 1, 0xAAAA; B: sel 2, 0xBBBB), each re-presented after its grant -> grants alternate A,B,A,B; `wen` high for 4 consecutive cycles. Without `WB_RR_EN` -> B,B,B,B.
- `rsv_en` with `rsv_sel`=5 -> `rsv_ok`=1 and `busy[5]`=1. A second `rsv_en` for 5 -> `rsv_ok`=0. B writes sel 5 -> `busy[5]` clears on the `wen` edge.
- With `busy[7]`=1 and `wen`=1, `selRd`=7 in the same cycle as `rsv_en`, `rsv_sel`=7 -> `rsv_ok`=1 and `busy[7]` stays 1.
- `busy`=0x00F0 while a write to R4 sits in the write stage, with `flush`=1 -> the next cycle has `busy`=0 and the R4 write still commits.
- `rst` asserted mid-cycle with `wen`=1 -> `wen`, `busy`, `selRd` and `rd` go to 0 immediately, with no clock edge required.
